// File: rtl/frame_buffer_reader.sv
// Frame buffer read-back: fetches one ROWS x COLS frame from SRAM a row at a time
// and serialises each row into a valid/ready pixel stream tagged with x/y.
module frame_buffer_reader #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int WORD_BITS = 24,
    parameter int ADDR_BITS = 24,
    parameter int BASE_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      layer_num,
    output logic                      read_enable,
    output logic                      write_enable,
    output logic [ADDR_BITS-1:0]      address,
    input  logic [COLS*WORD_BITS-1:0] read_data,
    output logic [WORD_BITS-1:0]      pixel_data,
    output logic [7:0]                pixel_x,
    output logic [7:0]                pixel_y,
    output logic                      pixel_last,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      busy,
    output logic                      frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        STREAM,
        DONE
    } state_e;

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    state_e                   state_q;
    logic [7:0]               row_q;
    logic [7:0]               col_q;
    logic                     layer_q;
    logic [ADDR_BITS-1:0]     addr_q;
    logic [COLS*WORD_BITS-1:0] row_buf_q;
    logic                     rd_en_q;
    logic                     valid_q;
    logic                     done_q;
    logic [7:0]               row_d;
    logic [ADDR_BITS-1:0]     next_addr_d;

    // Address arithmetic is done at ADDR_BITS width so it wraps silently.
    function automatic logic [ADDR_BITS-1:0] row_addr(input logic layer, input logic [7:0] row);
        return ADDR_BITS'(BASE_ADDR)
             + ADDR_BITS'(layer) * ADDR_BITS'(ROWS * COLS)
             + ADDR_BITS'(row) * ADDR_BITS'(COLS);
    endfunction

    always_comb begin
        row_d       = row_q + 8'd1;
        next_addr_d = row_addr(layer_q, row_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            layer_q   <= 1'b0;
            addr_q    <= '0;
            // NOTE: the row buffer is reset so pixel_data reads 0 out of reset; it is a register bank, not an SRAM macro.
            row_buf_q <= '0;
            rd_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make read_enable and frame_done single-cycle strobes.
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        layer_q <= layer_num;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= row_addr(layer_num, 8'd0);
                        rd_en_q <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    row_buf_q <= read_data;
                    valid_q   <= 1'b1;
                    state_q   <= STREAM;
                end
                STREAM: begin
                    if (pixel_ready) begin
                        if (col_q == LAST_COL) begin
                            col_q   <= '0;
                            valid_q <= 1'b0;
                            if (row_q != LAST_ROW) begin
                                row_q   <= row_d;
                                addr_q  <= next_addr_d;
                                rd_en_q <= 1'b1;
                                state_q <= READ;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_enable  = rd_en_q;
    assign write_enable = 1'b0;
    assign address      = addr_q;
    assign pixel_data   = row_buf_q[col_q*WORD_BITS +: WORD_BITS];
    assign pixel_x      = col_q;
    assign pixel_y      = row_q;
    assign pixel_valid  = valid_q;
    assign pixel_last   = valid_q && (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;

endmodule
